// File: rtl/common_pkg.sv
// Shared widths, fetch FSM states and PC helpers for the fetch path and instruction memory.
// Pure declarations; no latency or flow control of its own.
package common_pkg;

  localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 16;
  localparam int INSTRUCTION_WIDTH                = 32;
  localparam int PC_WIDTH                         = 32;
  localparam int INSTR_BYTES                      = 4;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Word index seen by the memory; upper PC bits are dropped, so the index wraps.
  function automatic logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] pc_to_word(
    input logic [PC_WIDTH-1:0] pc
  );
    return pc[INSTRUCTION_MEMORY_ADDRESS_WIDTH+1:2];
  endfunction

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return {pc[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_output_slot.sv
// Single-entry valid/ready register holding {pc, instruction}; load is only legal when free_o.
// One-cycle latency from load to vld_o; holds under backpressure, flush drops the entry.
module fetch_output_slot
  import common_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         load_i,
  input  logic [PC_WIDTH-1:0]          pc_i,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  input  logic                         rdy_i,
  output logic                         free_o,
  output logic                         vld_o,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [INSTRUCTION_WIDTH-1:0] instr_o
);

  logic                         vld_q;
  logic [PC_WIDTH-1:0]          pc_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;

  assign free_o = !vld_q || rdy_i;

  // Flush beats a simultaneous accept: the entry is dropped, not delivered twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (flush_i) begin
      vld_q <= 1'b0;
    end else if (load_i) begin
      vld_q   <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end else if (free_o) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o   = vld_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_memory.sv
// Word-addressed instruction store: combinational read, synchronous write port for image loading.
// Read data valid in the same cycle as the address; no flow control.
module instruction_memory
  import common_pkg::*;
(
  input  logic                                        clk,
  input  logic                                        write_enable,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] write_address,
  input  logic [INSTRUCTION_WIDTH-1:0]                write_data,
  input  logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_address,
  output logic [INSTRUCTION_WIDTH-1:0]                instruction_data
);

  logic [INSTRUCTION_WIDTH-1:0] mem_q [0:(1<<INSTRUCTION_MEMORY_ADDRESS_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem_q[write_address] <= write_data;
    end
  end

  assign instruction_data = mem_q[instruction_address];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC + BOOT/RUN/HALTED FSM feeding a registered slot to decode, one cycle address->valid.
// Holds PC and slot under backpressure; redirect squashes the slot. FETCH_PERF_COUNTER_EN adds fetch_count.
module instruction_fetch
  import common_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                                        clk,
  input  logic                                        rst,
  output logic [INSTRUCTION_MEMORY_ADDRESS_WIDTH-1:0] instruction_address,
  input  logic [INSTRUCTION_WIDTH-1:0]                instruction_data,
  input  logic                                        redirect_valid,
  input  logic [PC_WIDTH-1:0]                         redirect_pc,
  input  logic                                        halt_req,
  output logic                                        if_valid,
  input  logic                                        if_ready,
  output logic [INSTRUCTION_WIDTH-1:0]                if_instruction,
  output logic [PC_WIDTH-1:0]                         if_pc,
  output logic                                        misaligned,
  output logic [31:0]                                 fetch_count
);

  fetch_state_t        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic                misaligned_q;
  logic                slot_free;
  logic                redirect_take;
  logic                capture;

  // BOOT ignores redirects so the first fetch after reset is always RESET_PC.
  assign redirect_take = redirect_valid && (state_q != BOOT);
  assign capture       = (state_q == RUN) && slot_free && !redirect_valid && !halt_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else if (redirect_take) begin
      pc_q <= align_pc(redirect_pc);
      if (redirect_pc[1:0] != 2'b00) begin
        misaligned_q <= 1'b1;
      end
      state_q <= halt_req ? HALTED : RUN;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (halt_req) begin
            state_q <= HALTED;
          end else if (capture) begin
            pc_q <= pc_q + PC_WIDTH'(INSTR_BYTES);
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state_q <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign instruction_address = pc_to_word(pc_q);
  assign misaligned          = misaligned_q;

  fetch_output_slot u_slot (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_take),
    .load_i  (capture),
    .pc_i    (pc_q),
    .instr_i (instruction_data),
    .rdy_i   (if_ready),
    .free_o  (slot_free),
    .vld_o   (if_valid),
    .pc_o    (if_pc),
    .instr_o (if_instruction)
  );

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] fetch_count_q;

  // A squashed handshake is not a delivered instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else if (if_valid && if_ready && !redirect_take) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with the real instruction_memory: directed scenarios plus random traffic.
// Expected (pc, instruction) streams are queued on reset/redirect and popped on each accepted handshake.
`timescale 1ns/1ps
module tb_instruction_fetch;
  import common_pkg::*;

`ifdef FETCH_PERF_COUNTER_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction_address;
  logic [31:0] instruction_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        misaligned;
  logic [31:0] fetch_count;
  logic        mem_we;
  logic [15:0] mem_wa;
  logic [31:0] mem_wd;

  always #5 clk = ~clk;

  instruction_memory u_mem (
    .clk                 (clk),
    .write_enable        (mem_we),
    .write_address       (mem_wa),
    .write_data          (mem_wd),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data)
  );

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_address (instruction_address),
    .instruction_data    (instruction_data),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .halt_req            (halt_req),
    .if_valid            (if_valid),
    .if_ready            (if_ready),
    .if_instruction      (if_instruction),
    .if_pc               (if_pc),
    .misaligned          (misaligned),
    .fetch_count         (fetch_count)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [31:0] img [0:255];
  logic [31:0] img_hi [0:1];
  logic [31:0] boot_img [0:4];
  int unsigned model_count = 0;
  logic        model_mis = 1'b0;

  function automatic logic [31:0] img_word(input logic [31:0] pc);
    logic [15:0] idx;
    idx = pc[17:2];
    if (idx < 16'd256) return img[idx[7:0]];
    if (idx == 16'hFFFE) return img_hi[0];
    if (idx == 16'hFFFF) return img_hi[1];
    return 32'h0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // The accepted stream after a reset or redirect is simply sequential words from the target.
  task automatic push_stream(input logic [31:0] start);
    logic [31:0] p;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      p = start + 32'(4 * i);
      sb_q.push_back(exp_t'{pc: p, instr: img_word(p)});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    if_ready       = rdy;
    push_stream(32'h0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: counter and sticky flag every cycle, stream contents on every counted handshake.
  always @(negedge clk) begin
    if (rst) begin
      model_count = 0;
      model_mis   = 1'b0;
    end else begin
      chk("fetch_count", fetch_count, exp_cnt(int'(model_count)));
      chk("misaligned", 32'(misaligned), 32'(model_mis));
      if (if_valid && if_ready && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=unexpected handshake pc=%h expected=no handshake", if_pc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("hs_pc", if_pc, e.pc);
          chk("hs_instr", if_instruction, e.instr);
        end
        model_count++;
      end
      if (redirect_valid && redirect_pc[1:0] != 2'b00) model_mis = 1'b1;
    end
  end

  initial begin
    logic [31:0] t;
    int          since_redir;

    boot_img[0] = 32'h0210_3083;
    boot_img[1] = 32'hAFBF_CFDF;
    boot_img[2] = 32'h7034_EF55;
    boot_img[3] = 32'h1122_3344;
    boot_img[4] = 32'hDEAD_BEEF;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; if_ready = 1'b0;
    mem_we = 1'b0; mem_wa = '0; mem_wd = '0;

    for (int i = 0; i < 256; i++) begin
      img[i] = (i < 5) ? boot_img[i] : $urandom();
      mem_we = 1'b1; mem_wa = 16'(i); mem_wd = img[i];
      tick();
    end
    img_hi[0] = $urandom(); img_hi[1] = $urandom();
    mem_wa = 16'hFFFE; mem_wd = img_hi[0]; tick();
    mem_wa = 16'hFFFF; mem_wd = img_hi[1]; tick();
    mem_we = 1'b0;

    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instruction, 32'h0);
    chk("rst_mis", 32'(misaligned), 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_addr", 32'(instruction_address), 32'h0);

    // Reset release, ready held high: one instruction per cycle after BOOT.
    do_reset(1'b1);
    tick(); chk("boot_no_valid", 32'(if_valid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("seq_valid", 32'(if_valid), 32'h1);
      chk("seq_pc", if_pc, 32'(4 * i));
      chk("seq_instr", if_instruction, boot_img[i]);
      chk("seq_addr", 32'(instruction_address), 32'(i + 1));
    end
    tick(); chk("count_after5", fetch_count, exp_cnt(5));

    // Backpressure on the first instruction.
    do_reset(1'b0);
    tick(); chk("bp_boot", 32'(if_valid), 32'h0);
    tick(); chk("bp_first", if_instruction, 32'h0210_3083); chk("bp_addr0", 32'(instruction_address), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(if_valid), 32'h1);
      chk("bp_hold_instr", if_instruction, 32'h0210_3083);
      chk("bp_hold_addr", 32'(instruction_address), 32'h1);
    end
    if_ready = 1'b1;
    tick(); chk("bp_next_instr", if_instruction, 32'hAFBF_CFDF); chk("bp_next_pc", if_pc, 32'h4);

    // Redirect squashes the slot even with ready high.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_000C; push_stream(32'hC);
    tick(); redirect_valid = 1'b0;
    chk("redir_squash", 32'(if_valid), 32'h0);
    chk("redir_count", fetch_count, exp_cnt(1));
    tick(); chk("redir_valid", 32'(if_valid), 32'h1);
    chk("redir_pc", if_pc, 32'hC); chk("redir_instr", if_instruction, 32'h1122_3344);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0006; push_stream(32'h4);
    tick(); redirect_valid = 1'b0;
    chk("mis_set", 32'(misaligned), 32'h1);
    tick(); chk("mis_pc", if_pc, 32'h4); chk("mis_instr", if_instruction, 32'hAFBF_CFDF);

    // Halt for four cycles with a valid slot and ready high.
    halt_req = 1'b1;
    tick(); chk("halt_drain", 32'(if_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("halt_idle", 32'(if_valid), 32'h0);
    end
    halt_req = 1'b0;
    tick(); chk("halt_resume_gap", 32'(if_valid), 32'h0);
    tick(); chk("halt_resume_valid", 32'(if_valid), 32'h1);
    chk("halt_resume_pc", if_pc, 32'h8); chk("halt_resume_instr", if_instruction, 32'h7034_EF55);
    chk("mis_sticky", 32'(misaligned), 32'h1);

    // Reset in the middle of the stream.
    rst = 1'b1; push_stream(32'h0);
    tick();
    chk("mrst_valid", 32'(if_valid), 32'h0);
    chk("mrst_addr", 32'(instruction_address), 32'h0);
    chk("mrst_count", fetch_count, 32'h0);
    chk("mrst_mis", 32'(misaligned), 32'h0);
    rst = 1'b0;
    tick();

    // Address truncation and 32-bit PC wrap.
    redirect_valid = 1'b1; redirect_pc = 32'h0003_FFF8; push_stream(32'h0003_FFF8);
    tick(); redirect_valid = 1'b0;
    chk("wrap_addr_hi", 32'(instruction_address), 32'h0000_FFFE);
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; push_stream(32'hFFFF_FFFC);
    tick(); redirect_valid = 1'b0;
    chk("wrap_addr_top", 32'(instruction_address), 32'h0000_FFFF);
    tick();
    chk("wrap_addr_zero", 32'(instruction_address), 32'h0);
    chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
    repeat (3) tick();

    // Random traffic against the stream model.
    do_reset(1'b1);
    tick();
    since_redir = 0;
    for (int c = 0; c < 3000; c++) begin
      if_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'b1);
        tick();
        since_redir = 0;
        continue;
      end
      if (since_redir > 24 || $urandom_range(0, 11) == 0) begin
        t = $urandom_range(0, 800);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        push_stream({t[31:2], 2'b00});
        since_redir = 0;
      end else begin
        redirect_valid = 1'b0;
        since_redir++;
      end
      tick();
    end
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of instruction_memory: holds the program counter and drives the word address into the combinational instruction memory.
- Registers the returned instruction word, together with its PC, into a single output slot toward decode, using a valid/ready handshake.
- Supports branch/jump redirect with squash, plus a halt/resume control.

Parameters:
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; bits [1:0] must be zero.
- Address/data widths come from common_pkg: INSTRUCTION_MEMORY_ADDRESS_WIDTH (16), INSTRUCTION_WIDTH (32). These are package constants, not module parameters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instruction_address  out  INSTRUCTION_MEMORY_ADDRESS_WIDTH  word index to memory; equals pc_q[ADDR_W+1:2], combinational from pc_q.
- instruction_data  in  INSTRUCTION_WIDTH  memory read data, valid in the same cycle as the address.
- redirect_valid  in  1  one-cycle branch/jump redirect request.
- redirect_pc  in  32  redirect target byte address.
- halt_req  in  1  level; stop fetching while high.
- if_valid  out  1  output slot holds a valid instruction.
- if_ready  in  1  decode accepts the slot this cycle.
- if_instruction  out  INSTRUCTION_WIDTH  registered instruction.
- if_pc  out  32  byte PC of if_instruction.
- misaligned  out  1  sticky; set when a redirect target has bits [1:0] != 0.
- fetch_count  out  32  accepted-instruction counter (see Optional Feature).

Behaviour:
- Clock/reset: one clock domain. Reset is synchronous and active-high; the clock port is clk and the reset port is rst.
- Reset values: pc_q=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, misaligned=0, fetch_count=0, state=BOOT.
- Reset mid-operation: reset wins over every other input in that cycle; any in-flight slot is discarded.
- States:
  - BOOT: one cycle after reset deasserts; no capture, then go to RUN.
  - RUN: normal fetching.
  - HALTED: no capture; pc_q held.
- Slot free: free = !if_valid || if_ready.
- RUN capture: when free, !redirect_valid and !halt_req:
  - if_instruction<=instruction_data, if_pc<=pc_q, if_valid<=1, pc_q<=pc_q+4.
  - Latency: one cycle from address presentation to if_valid.
- RUN hold: when not free, the slot and pc_q are held stable; instruction_address stays constant.
- RUN drain: when free and not capturing, if_valid<=0.
- Redirect (highest priority after reset, any state except BOOT):
  - pc_q<={redirect_pc[31:2],2'b00}; if_valid<=0, squashing the slot even when if_ready=1 that cycle (the handshake does not count).
  - If redirect_pc[1:0]!=0, misaligned<=1; it is cleared only by reset.
  - Next state: RUN if !halt_req, else HALTED.
- halt_req in RUN (no redirect):
  - Go to HALTED with no new capture.
  - The existing slot remains valid until accepted; if_ready still works.
- HALTED: return to RUN in the cycle after halt_req falls; a redirect while halted updates pc_q.
- Redirect and halt_req together: redirect is applied, then go to HALTED.
- Wrap-around:
  - pc_q+4 wraps modulo 2^32.
  - instruction_address is truncated, so word index 16'hFFFF is followed by 16'h0000 when pc bits above ADDR_W+1 are zero.
- Output registers come straight from flops; the only combinational output is instruction_address.

Optional Feature:
- Macro: FETCH_PERF_COUNTER_EN.
- Defined: fetch_count increments by 1 on each cycle with if_valid && if_ready and no redirect; wraps at 2^32; cleared by reset.
- Undefined: fetch_count is tied to 0; no counter flops are synthesised.

Decomposition:
- Add to common_pkg:
  - fetch_state_t enum {BOOT, RUN, HALTED}.
  - PC_WIDTH=32.
  - INSTR_BYTES=4.
- Reuse the existing INSTRUCTION_MEMORY_ADDRESS_WIDTH and INSTRUCTION_WIDTH.
- One natural sub-module, fetch_output_slot: a single-entry valid/ready register holding {pc, instruction}, with flush input.
- The PC/FSM logic stays in instruction_fetch.
- The bench instantiates instruction_fetch with the real instruction_memory.

Test Plan:
- Reset release with if_ready=1 and image mem[0..4]=02103083, AFBFCFDF, 7034EF55, 11223344, DEADBEEF:
  - No valid in the BOOT cycle.
  - Then one instruction per cycle: 02103083@pc 0, AFBFCFDF@4, 7034EF55@8, 11223344@12, DEADBEEF@16.
- Backpressure: if_ready=0 for 3 cycles after the first valid → if_instruction stays 02103083, instruction_address stays 1; when if_ready=1, AFBFCFDF follows next cycle.
- Redirect to 32'h0000_000C while the slot holds AFBFCFDF with if_ready=1:
  - Slot squashed (if_valid=0 next cycle); fetch_count not incremented.
  - Next valid is 11223344 with if_pc=0xC.
- Redirect to 32'h0000_0006 → misaligned=1 (sticky); fetch resumes at pc 4 (AFBFCFDF).
- halt_req held 4 cycles while the slot is valid and if_ready=1:
  - Slot drains once.
  - No further valid while halted.
  - Fetch resumes at the held pc the cycle after halt_req falls.
- Reset asserted mid-stream with a valid slot → next cycle if_valid=0, pc restarts at 0, fetch_count=0.
- With FETCH_PERF_COUNTER_EN: after 5 accepted instructions fetch_count=5.
